// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: bundles the three LSU-facing channels.
//   req_*  execute stage -> LSU (valid/ready, decoded load/store fields)
//   mem_*  LSU <-> single-port data memory (req/gnt, then rvalid)
//   rsp_*  LSU -> writeback (one-cycle completion pulse)
// Modports:
//   slave  : the LSU's view. It is the target of the execute-stage request
//            and drives the memory request and the writeback response.
//   master : the environment's view (execute stage, memory and writeback).
interface lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [4:0]  req_rd;

  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        rsp_valid;
  logic [4:0]  rsp_rd;
  logic        rsp_wb;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, req_rd,
    output req_ready,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output rsp_valid, rsp_rd, rsp_wb, rsp_rdata, rsp_err
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, req_rd,
    input  req_ready,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  rsp_valid, rsp_rd, rsp_wb, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: non-pipelined load/store sequencer between execute and a
// single-port data memory. One access outstanding at a time.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : lsu_ctrl_if.slave -- request in, memory req/gnt/rvalid,
//                writeback response out
// Parameters:
//   TIMEOUT    : cycles allowed waiting for rvalid after grant before the
//                access is aborted with an error; 0 disables (0..65535)
// Flow: IDLE -accept-> REQ -gnt-> WAIT -rvalid/timeout-> RESP -> IDLE.
// Misaligned or illegal-size requests skip memory: IDLE -> RESP with error.
// Every output is decoded from state or registered request fields, so there
// is no combinational path from any input to any output.

// Per-byte-lane byte-enable and store-data steering. Lane LANE takes the
// store byte that lands on it after shifting left by the byte offset; the
// rotation fills unused lanes with copies, which BE masks out.
module lsu_lane #(
  parameter int unsigned LANE = 0
) (
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic        be,
  output logic [7:0]  wbyte
);
  logic [1:0] lane_idx;
  logic [1:0] sel;

  assign lane_idx = 2'(LANE);
  assign sel      = lane_idx - off;
  assign wbyte    = wdata[{sel, 3'b000} +: 8];

  always_comb begin
    be = 1'b0;
    case (size)
      2'b00:   be = (off == lane_idx);
      2'b01:   be = (off == lane_idx) || ((off + 2'd1) == lane_idx);
      2'b10:   be = 1'b1;
      default: be = 1'b0;
    endcase
  end
endmodule

module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 256
) (
  input logic       clk,
  input logic       rst_n,
  lsu_ctrl_if.slave bus
);
  localparam int unsigned NUM_LANES = 4;
  localparam logic [15:0] TMO_LAST  = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [4:0]  rd;
  } req_t;

  state_t state_q, state_d;
  req_t   req_q;
  logic [NUM_LANES-1:0]      be_q;
  logic [31:0]               wdata_q;
  logic [31:0]               rdata_q;
  logic                      err_q;
  logic [15:0]               cnt_q;

  logic [NUM_LANES-1:0]      lane_be;
  logic [NUM_LANES-1:0][7:0] lane_wdata;
  logic                      bad;
  logic                      tmo_hit;
  logic [31:0]               rshift;
  logic [31:0]               ld_data;

  // Steering from the live request; captured at accept.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    lsu_lane #(.LANE(l)) u_lane (
      .size  (bus.req_size),
      .off   (bus.req_addr[1:0]),
      .wdata (bus.req_wdata),
      .be    (lane_be[l]),
      .wbyte (lane_wdata[l])
    );
  end

  always_comb begin
    bad = 1'b0;
    case (bus.req_size)
      2'b01:   bad = bus.req_addr[0];
      2'b10:   bad = (bus.req_addr[1:0] != 2'b00);
      2'b11:   bad = 1'b1;
      default: bad = 1'b0;
    endcase
  end

  // rvalid has priority over a timeout landing in the same cycle.
  assign tmo_hit = (TIMEOUT != 0) && (cnt_q == TMO_LAST);

  // Load extraction uses registered offset/size so it depends on the
  // request that is actually in flight.
  assign rshift = bus.mem_rdata >> {req_q.addr[1:0], 3'b000};

  always_comb begin
    ld_data = rshift;
    case (req_q.size)
      2'b00:   ld_data = req_q.uns ? {24'd0, rshift[7:0]}
                                   : {{24{rshift[7]}}, rshift[7:0]};
      2'b01:   ld_data = req_q.uns ? {16'd0, rshift[15:0]}
                                   : {{16{rshift[15]}}, rshift[15:0]};
      default: ld_data = rshift;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.req_valid) state_d = bad ? S_RESP : S_REQ;
      S_REQ:  if (bus.mem_gnt)   state_d = S_WAIT;
      S_WAIT: if (bus.mem_rvalid || tmo_hit) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.req_valid) begin
          req_q.we   <= bus.req_we;
          req_q.addr <= bus.req_addr;
          req_q.size <= bus.req_size;
          req_q.uns  <= bus.req_unsigned;
          req_q.rd   <= bus.req_rd;
          be_q       <= bad ? '0 : lane_be;
          wdata_q    <= bad ? '0 : lane_wdata;
          rdata_q    <= '0;
          err_q      <= bad;
          cnt_q      <= '0;
        end
        S_WAIT: begin
          // Saturate so a disabled watchdog never wraps into a false hit.
          if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
          if (bus.mem_rvalid)  rdata_q <= req_q.we ? 32'd0 : ld_data;
          else if (tmo_hit)    err_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.mem_req   = (state_q == S_REQ);
  assign bus.mem_we    = req_q.we;
  assign bus.mem_addr  = {req_q.addr[31:2], 2'b00};
  assign bus.mem_be    = be_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rd    = req_q.rd;
  assign bus.rsp_err   = (state_q == S_RESP) && err_q;
  assign bus.rsp_wb    = (state_q == S_RESP) && !req_q.we && !err_q && (req_q.rd != 5'd0);
  assign bus.rsp_rdata = (state_q == S_RESP) ? rdata_q : 32'd0;
endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer between the execute stage and the single-port data memory. Accepts one decoded load or store per transaction (size BYTE/HWORD/WORD, signed/unsigned per funct3), checks alignment, and generates the word-aligned address, byte enables and lane-shifted store data. It drives the memory req/gnt/rvalid handshake and returns sign- or zero-extended load data with its destination register to writeback. Non-pipelined: one outstanding access.

## Interface
- TIMEOUT, 256: cycles allowed in WAIT before aborting with error; 0 disables the watchdog; legal range 0..65535.
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  1  execute stage presents a memory op
- req_ready_o  out  1  LSU can accept; high only in IDLE
- req_we_i  in  1  1 = store, 0 = load
- req_addr_i  in  32  byte address (rs1 + imm)
- req_wdata_i  in  32  store data (rs2), right-aligned
- req_size_i  in  2  00 BYTE, 01 HWORD, 10 WORD, 11 illegal
- req_unsigned_i  in  1  funct3[2]; 0 signed, 1 unsigned (loads only)
- req_rd_i  in  5  load destination register
- mem_req_o  out  1  memory request
- mem_gnt_i  in  1  memory accepted request this cycle
- mem_we_o  out  1  write strobe
- mem_addr_o  out  32  {addr[31:2], 2'b00}
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  32  lane-shifted store data
- mem_rvalid_i  in  1  response (read data or write ack)
- mem_rdata_i  in  32  raw read word
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_rd_o  out  5  destination register
- rsp_wb_o  out  1  write rsp_rdata_o to rsp_rd_o (load, no error, rd != 0)
- rsp_rdata_o  out  32  extended load data; 0 for stores/errors
- rsp_err_o  out  1  misaligned, illegal size, or timeout

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready_o=1. On req_valid_i, register all req fields → REQ, unless misaligned/illegal → RESP with error, no memory access.
- Misaligned: HWORD with addr[0]=1; WORD with addr[1:0]!=0; size 11 always illegal.
- Byte enables: BYTE 4'b0001<<addr[1:0]; HWORD 4'b0011<<addr[1:0]; WORD 4'b1111. Loads drive the same BE.
- Store data: wdata << (8*addr[1:0]); unused lanes carry replicated copies, don't-care for verification (BE governs).
- REQ: mem_req_o=1, address/we/be/wdata stable until gnt. On mem_gnt_i → WAIT. No withdrawal once asserted.
- WAIT: mem_req_o=0; timeout counter increments per cycle. On mem_rvalid_i: loads extract lane rdata >> (8*addr[1:0]), then sign-extend bit 7/15 (signed) or zero-extend (unsigned); WORD passes through. → RESP. If counter reaches TIMEOUT (≠0) with no rvalid → RESP with error.
- RESP: rsp_valid_o=1 for exactly one cycle, → IDLE. rsp_err_o set on error; rsp_wb_o=0 on store, error, or rd=x0.
- mem_rvalid_i outside WAIT is ignored (a late response after a timeout is dropped).
- Asynchronous reset at any time: state → IDLE, counter cleared, outgoing request dropped immediately.

## Timing
- Reset values: req_ready_o=1 (IDLE), all other outputs 0 (mem_addr_o, mem_be_o, mem_wdata_o, rsp_rdata_o, rsp_rd_o included).
- All outputs registered or decoded from state/registered fields only; no input-to-output combinational path.
- Accept at cycle N; mem_req_o at N+1; with gnt at N+1 and rvalid at N+2, rsp_valid_o at N+3. Minimum latency 3 cycles; next accept at N+4 (req_ready_o high again at N+4).
- Error path: accept N, rsp_valid_o with rsp_err_o at N+1.
- Each gnt stall cycle adds one cycle; each rvalid wait cycle adds one cycle.
- Timeout: rsp_err_o asserted TIMEOUT+1 cycles after the gnt cycle.

## Test plan
- LB signed, addr 0x1003, mem word 0x80FF_1234 → be 4'b1000, mem_addr 0x1000, rsp_rdata 0xFFFF_FF80, rsp_wb=1, rsp_valid at accept+3.
- LHU addr 0x2002, word 0xBEEF_0000 → be 4'b1100, rdata 0x0000_BEEF; LH same → 0xFFFF_BEEF.
- SB addr 0x3001, wdata 0x1234_56AB → mem_we=1, be 4'b0010, mem_wdata[15:8]=0xAB; gnt held low 3 cycles → request stable throughout, rsp_valid at accept+6, rsp_wb=0.
- LW addr 0x4002 and size 11 → no mem_req_o, rsp_valid+rsp_err at accept+1; LW addr 0x4000 rd=x0 → rsp_wb=0.
- TIMEOUT=4, no rvalid → rsp_err at gnt+5; late rvalid afterwards ignored, next request proceeds normally.
- rst_n low during REQ → mem_req_o drops immediately, all outputs at reset values, req_ready_o=1 after release.
